// File: rtl/lms_ctr_onchip_mem_arbiter_pkg.sv
// Shared types and grant rule for the lms_ctr on-chip RAM arbiter.
package lms_ctr_mem_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} mst_e;

  // One-hot grant; on contention round-robin favours the master that did not win last.
  function automatic logic [1:0] grant_sel(input logic [1:0] req, input logic block,
                                           input mst_e last, input logic rr);
    logic [1:0] g;
    g = 2'b00;
    if (!block) begin
      if (req == 2'b11) g = (rr && last == M0) ? 2'b10 : 2'b01;
      else              g = req;
    end
    return g;
  endfunction
endpackage

// File: rtl/lms_ctr_onchip_mem_arbiter_if.sv
// Pipelined Avalon-MM port as seen between one master and the arbiter.
interface lms_ctr_mem_avl_if
  import lms_ctr_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic                readdatavalid;
  logic [DATA_W-1:0]   readdata;

  modport master (output address, byteenable, read, write, writedata,
                  input  waitrequest, readdatavalid, readdata);
  modport slave  (input  address, byteenable, read, write, writedata,
                  output waitrequest, readdatavalid, readdata);
endinterface

// File: rtl/lms_ctr_onchip_mem_arbiter_rr_arb2.sv
// Two-way arbiter: combinational grant plus the last-grant history register.
module lms_ctr_rr_arb2
  import lms_ctr_mem_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       block_i,
  output logic [1:0] gnt_o
);
  mst_e last_q, last_d;

  assign gnt_o = grant_sel(req_i, block_i, last_q, ROUND_ROBIN);

  always_comb begin
    last_d = last_q;
    if (gnt_o[1])      last_d = M1;
    else if (gnt_o[0]) last_d = M0;
  end

  // Reset to M1 so the first contention goes to the CPU master.
  always_ff @(posedge clk) begin
    if (reset) last_q <= M1;
    else       last_q <= last_d;
  end
endmodule

// File: rtl/lms_ctr_onchip_mem_arbiter.sv
// Shares the single RAM port between m0 (CPU) and m1; 1-cycle fixed read latency.
module lms_ctr_onchip_mem_arbiter
  import lms_ctr_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  lms_ctr_mem_avl_if.slave    m0,
  lms_ctr_mem_avl_if.slave    m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);
  logic [1:0] req, gnt;
  logic       rd_acc;
  logic       rd_pending_q, rd_pending_d;
  mst_e       rd_owner_q, rd_owner_d;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  lms_ctr_rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .block_i (reset_req),
    .gnt_o   (gnt)
  );

  assign m0.waitrequest = ~gnt[0];
  assign m1.waitrequest = ~gnt[1];

  // Without a grant the mux parks on m0 so the RAM inputs stay deterministic.
  always_comb begin
    mem_address    = m0.address;
    mem_byteenable = m0.byteenable;
    mem_writedata  = m0.writedata;
    if (gnt[1]) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
    end
  end

  assign mem_chipselect = |gnt;
  assign mem_write      = (gnt[0] & m0.write) | (gnt[1] & m1.write);
  assign mem_clken      = ~reset_req;

  assign rd_acc       = (gnt[0] & m0.read) | (gnt[1] & m1.read);
  assign rd_pending_d = rd_acc;
  assign rd_owner_d   = rd_acc ? (gnt[1] ? M1 : M0) : rd_owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= M0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Gating with reset drops a return that is in flight when reset hits.
  assign m0.readdatavalid = rd_pending_q & (rd_owner_q == M0) & ~reset;
  assign m1.readdatavalid = rd_pending_q & (rd_owner_q == M1) & ~reset;
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
endmodule

// File: tb/tb_lms_ctr_onchip_mem_arbiter.sv
// Bench for the two-master RAM arbiter: round-robin and fixed-priority instances with RAM models.
module tb_lms_ctr_onchip_mem_arbiter;
  import lms_ctr_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, reset_req, ram_init;
  logic        rd0, wr0, rd1, wr1;
  logic [9:0]  ad0, ad1;
  logic [3:0]  be0, be1;
  logic [31:0] wd0, wd1;

  lms_ctr_mem_avl_if #(.ADDR_W(10), .DATA_W(32)) a0(), a1(), f0(), f1();
  assign a0.address = ad0; assign a0.byteenable = be0; assign a0.read = rd0; assign a0.write = wr0; assign a0.writedata = wd0;
  assign a1.address = ad1; assign a1.byteenable = be1; assign a1.read = rd1; assign a1.write = wr1; assign a1.writedata = wd1;
  assign f0.address = ad0; assign f0.byteenable = be0; assign f0.read = rd0; assign f0.write = wr0; assign f0.writedata = wd0;
  assign f1.address = ad1; assign f1.byteenable = be1; assign f1.read = rd1; assign f1.write = wr1; assign f1.writedata = wd1;

  logic [9:0]  ma_r, ma_f;
  logic [3:0]  mbe_r, mbe_f;
  logic        mcs_r, mw_r, mck_r, mcs_f, mw_f, mck_f;
  logic [31:0] mwd_r, mq_r, mwd_f, mq_f;

  lms_ctr_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .reset_req(reset_req), .m0(a0), .m1(a1),
    .mem_address(ma_r), .mem_byteenable(mbe_r), .mem_chipselect(mcs_r), .mem_write(mw_r),
    .mem_writedata(mwd_r), .mem_clken(mck_r), .mem_readdata(mq_r));

  lms_ctr_onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset), .reset_req(reset_req), .m0(f0), .m1(f1),
    .mem_address(ma_f), .mem_byteenable(mbe_f), .mem_chipselect(mcs_f), .mem_write(mw_f),
    .mem_writedata(mwd_f), .mem_clken(mck_f), .mem_readdata(mq_f));

  // RAM models: registered address, unregistered q, byte-enabled writes, clken gated.
  logic [31:0] ram_r [1024];
  logic [31:0] ram_f [1024];
  logic [9:0]  rq_r, rq_f;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) begin ram_r[i] <= '0; ram_f[i] <= '0; end
      rq_r <= '0; rq_f <= '0;
    end else begin
      if (mck_r) begin
        rq_r <= ma_r;
        if (mcs_r && mw_r) for (int b = 0; b < 4; b++) if (mbe_r[b]) ram_r[ma_r][8*b +: 8] <= mwd_r[8*b +: 8];
      end
      if (mck_f) begin
        rq_f <= ma_f;
        if (mcs_f && mw_f) for (int b = 0; b < 4; b++) if (mbe_f[b]) ram_f[ma_f][8*b +: 8] <= mwd_f[8*b +: 8];
      end
    end
  end
  assign mq_r = ram_r[rq_r];
  assign mq_f = ram_f[rq_f];

  // Reference model of the round-robin instance: memory image, last winner, pending read.
  logic [31:0] mdl [1024];
  int          last, pend, owner;
  logic [31:0] pdata;
  int          checks, failures;

  function automatic int exp_win();
    bit q0, q1;
    q0 = rd0 | wr0;
    q1 = rd1 | wr1;
    if (reset_req) return -1;
    if (q0 && q1)  return (last == 0) ? 1 : 0;
    if (q0)        return 0;
    if (q1)        return 1;
    return -1;
  endfunction

  task automatic tick();
    int w;
    logic [9:0] a; logic [3:0] be; logic [31:0] d; logic r, wr;
    w = exp_win();
    a = (w == 1) ? ad1 : ad0; be = (w == 1) ? be1 : be0; d = (w == 1) ? wd1 : wd0;
    r = (w == 1) ? rd1 : rd0; wr = (w == 1) ? wr1 : wr0;
    @(posedge clk);
    if (reset) begin
      last = 1; pend = 0;
    end else begin
      pend = 0;
      if (w >= 0) begin
        if (wr) for (int b = 0; b < 4; b++) if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
        if (r) begin pend = 1; owner = w; pdata = mdl[a]; end
        last = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
  endtask

  task automatic set_m0(input logic r, input logic w, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    rd0 = r; wr0 = w; ad0 = a; be0 = be; wd0 = d;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
    rd1 = r; wr1 = w; ad1 = a; be1 = be; wd1 = d;
  endtask

  task automatic test_reset();
    reset = 1; ram_init = 1; reset_req = 0; idle();
    set_m0(0, 0, 0, 0, 0); set_m1(0, 0, 0, 0, 0);
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    last = 1; pend = 0; owner = 0; pdata = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (a0.readdatavalid !== 1'b0 || a1.readdatavalid !== 1'b0) begin failures++; $display("FAIL reset_rdv got=%b%b exp=00", a0.readdatavalid, a1.readdatavalid); end
      checks++; if (a0.waitrequest !== 1'b1 || a1.waitrequest !== 1'b1) begin failures++; $display("FAIL reset_wait got=%b%b exp=11", a0.waitrequest, a1.waitrequest); end
      checks++; if (mcs_r !== 1'b0 || mck_r !== 1'b1) begin failures++; $display("FAIL reset_mem cs=%b clken=%b exp cs=0 clken=1", mcs_r, mck_r); end
      tick();
    end
    reset = 0; ram_init = 0;
  endtask

  task automatic test_single_m0();
    set_m0(0, 1, 10'h005, 4'hF, 32'hDEADBEEF); #1;
    checks++; if (a0.waitrequest !== 1'b0) begin failures++; $display("FAIL single_wr_wait got=%b exp=0", a0.waitrequest); end
    checks++; if (mcs_r !== 1'b1 || mw_r !== 1'b1 || ma_r !== 10'h005) begin failures++; $display("FAIL single_wr_mem cs=%b we=%b addr=%h exp 1 1 005", mcs_r, mw_r, ma_r); end
    tick();
    set_m0(1, 0, 10'h005, 4'hF, 0); #1;
    checks++; if (a0.waitrequest !== 1'b0) begin failures++; $display("FAIL single_rd_wait got=%b exp=0", a0.waitrequest); end
    checks++; if (a0.readdatavalid !== 1'b0) begin failures++; $display("FAIL write_no_rdv got=%b exp=0", a0.readdatavalid); end
    tick();
    idle(); #1;
    checks++; if (a0.readdatavalid !== 1'b1 || a0.readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rd_data rdv=%b data=%h exp 1 deadbeef", a0.readdatavalid, a0.readdata); end
    checks++; if (a1.readdatavalid !== 1'b0) begin failures++; $display("FAIL single_rd_m1rdv got=%b exp=0", a1.readdatavalid); end
    tick();
  endtask

  task automatic test_byte_lane();
    set_m0(0, 1, 10'h3FF, 4'hF, 32'h11223344); tick();
    set_m0(0, 1, 10'h3FF, 4'h2, 32'h0000AA00); tick();
    set_m0(1, 0, 10'h3FF, 4'hF, 0); tick();
    idle(); #1;
    checks++; if (a0.readdatavalid !== 1'b1 || a0.readdata !== 32'h1122AA44) begin failures++; $display("FAIL byte_lane rdv=%b data=%h exp 1 1122aa44", a0.readdatavalid, a0.readdata); end
    checks++; if (ram_r[0] !== 32'h0) begin failures++; $display("FAIL byte_lane_wrap ram[0]=%h exp=0", ram_r[0]); end
    tick();
  endtask

  task automatic test_rr_contention();
    for (int k = 0; k < 8; k++) begin
      idle(); set_m0(0, 1, 10'h010 + 10'(k), 4'hF, $urandom); tick();
    end
    for (int k = 0; k < 8; k++) begin
      idle(); set_m1(0, 1, 10'h020 + 10'(k), 4'hF, $urandom); tick();
    end
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin set_m0(1, 0, 10'h010 + 10'(k), 4'hF, 0); set_m1(1, 0, 10'h020 + 10'(k), 4'hF, 0); end
      else idle();
      #1;
      if (k < 8) begin
        checks++; if (a0.waitrequest !== k[0] || a1.waitrequest !== !k[0]) begin failures++; $display("FAIL rr_grant k=%0d wait=%b%b exp=%b%b", k, a0.waitrequest, a1.waitrequest, k[0], !k[0]); end
      end
      if (k > 0) begin
        logic pw; logic [31:0] ed;
        pw = 1'(k - 1);
        ed = pw ? mdl[10'h020 + 10'(k - 1)] : mdl[10'h010 + 10'(k - 1)];
        checks++; if (a0.readdatavalid !== !pw || a1.readdatavalid !== pw) begin failures++; $display("FAIL rr_rdv k=%0d rdv=%b%b exp=%b%b", k, a0.readdatavalid, a1.readdatavalid, !pw, pw); end
        checks++; if (mq_r !== ed) begin failures++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, mq_r, ed); end
      end
      tick();
    end
  endtask

  task automatic test_fixed_priority();
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin set_m0(1, 0, 10'h010 + 10'(k), 4'hF, 0); set_m1(1, 0, 10'h020 + 10'(k), 4'hF, 0); end
      else idle();
      #1;
      if (k < 8) begin
        checks++; if (f0.waitrequest !== 1'b0 || f1.waitrequest !== 1'b1) begin failures++; $display("FAIL fp_grant k=%0d wait=%b%b exp=01", k, f0.waitrequest, f1.waitrequest); end
      end
      if (k > 0) begin
        checks++; if (f0.readdatavalid !== 1'b1 || f1.readdatavalid !== 1'b0) begin failures++; $display("FAIL fp_rdv k=%0d rdv=%b%b exp=10", k, f0.readdatavalid, f1.readdatavalid); end
        checks++; if (f0.readdata !== mdl[10'h010 + 10'(k - 1)]) begin failures++; $display("FAIL fp_data k=%0d got=%h exp=%h", k, f0.readdata, mdl[10'h010 + 10'(k - 1)]); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int k = 0; k < 3; k++) begin set_m1(0, 1, 10'(k), 4'hF, $urandom); tick(); end
    for (int k = 0; k < 5; k++) begin
      if (k < 3) set_m1(1, 0, 10'(k), 4'hF, 0); else idle();
      #1;
      if (k < 3) begin
        checks++; if (a1.waitrequest !== 1'b0) begin failures++; $display("FAIL b2b_wait k=%0d got=%b exp=0", k, a1.waitrequest); end
      end
      if (k >= 1 && k <= 3) begin
        checks++; if (a1.readdatavalid !== 1'b1 || a1.readdata !== mdl[k - 1]) begin failures++; $display("FAIL b2b_data k=%0d rdv=%b data=%h exp 1 %h", k, a1.readdatavalid, a1.readdata, mdl[k - 1]); end
      end
      if (k == 4) begin
        checks++; if (a1.readdatavalid !== 1'b0) begin failures++; $display("FAIL b2b_end rdv=%b exp=0", a1.readdatavalid); end
      end
      tick();
    end
  endtask

  task automatic test_reset_req();
    set_m0(1, 0, 10'h010, 4'hF, 0); set_m1(1, 0, 10'h020, 4'hF, 0);
    reset_req = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (a0.waitrequest !== 1'b1 || a1.waitrequest !== 1'b1) begin failures++; $display("FAIL rreq_wait got=%b%b exp=11", a0.waitrequest, a1.waitrequest); end
      checks++; if (mcs_r !== 1'b0 || mck_r !== 1'b0) begin failures++; $display("FAIL rreq_mem cs=%b clken=%b exp 0 0", mcs_r, mck_r); end
      tick();
    end
    reset_req = 0; #1;
    checks++; if (a0.waitrequest !== 1'b0 || a1.waitrequest !== 1'b1) begin failures++; $display("FAIL rreq_release wait=%b%b exp=01", a0.waitrequest, a1.waitrequest); end
    tick();
    idle(); #1;
    checks++; if (a0.readdatavalid !== 1'b1 || a0.readdata !== mdl[10'h010]) begin failures++; $display("FAIL rreq_data rdv=%b data=%h exp 1 %h", a0.readdatavalid, a0.readdata, mdl[10'h010]); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_m0(1, 0, 10'h005, 4'hF, 0); tick();
    idle(); reset = 1; #1;
    checks++; if (a0.readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_rdv got=%b exp=0", a0.readdatavalid); end
    tick();
    reset = 0; #1;
    checks++; if (a0.readdatavalid !== 1'b0 || a1.readdatavalid !== 1'b0) begin failures++; $display("FAIL midrst_after rdv=%b%b exp=00", a0.readdatavalid, a1.readdatavalid); end
    tick();
    set_m0(1, 0, 10'h005, 4'hF, 0); #1;
    checks++; if (a0.waitrequest !== 1'b0) begin failures++; $display("FAIL midrst_fresh_wait got=%b exp=0", a0.waitrequest); end
    tick();
    idle(); #1;
    checks++; if (a0.readdatavalid !== 1'b1 || a0.readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL midrst_fresh rdv=%b data=%h exp 1 deadbeef", a0.readdatavalid, a0.readdata); end
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      int op0, op1, w;
      op0 = $urandom_range(0, 2); op1 = $urandom_range(0, 2);
      reset_req = ($urandom_range(0, 9) == 0);
      set_m0(op0 == 1, op0 == 2, 10'($urandom_range(0, 15)), 4'($urandom), $urandom);
      set_m1(op1 == 1, op1 == 2, 10'($urandom_range(0, 15)), 4'($urandom), $urandom);
      #1;
      w = exp_win();
      checks++; if (a0.waitrequest !== (w != 0) || a1.waitrequest !== (w != 1)) begin failures++; $display("FAIL rnd_wait k=%0d got=%b%b exp=%b%b", k, a0.waitrequest, a1.waitrequest, w != 0, w != 1); end
      checks++; if (mcs_r !== (w >= 0) || mw_r !== ((w == 0 && wr0) || (w == 1 && wr1)) || mck_r !== !reset_req) begin failures++; $display("FAIL rnd_memctl k=%0d cs=%b we=%b ck=%b w=%0d", k, mcs_r, mw_r, mck_r, w); end
      checks++; if (ma_r !== ((w == 1) ? ad1 : ad0) || mwd_r !== ((w == 1) ? wd1 : wd0) || mbe_r !== ((w == 1) ? be1 : be0)) begin failures++; $display("FAIL rnd_memmux k=%0d addr=%h w=%0d", k, ma_r, w); end
      checks++; if (a0.readdatavalid !== (pend == 1 && owner == 0) || a1.readdatavalid !== (pend == 1 && owner == 1)) begin failures++; $display("FAIL rnd_rdv k=%0d rdv=%b%b pend=%0d owner=%0d", k, a0.readdatavalid, a1.readdatavalid, pend, owner); end
      if (pend == 1 && !reset_req) begin
        checks++; if (mq_r !== pdata) begin failures++; $display("FAIL rnd_data k=%0d got=%h exp=%h", k, mq_r, pdata); end
      end
      tick();
    end
    reset_req = 0; idle();
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_single_m0();
    test_byte_lane();
    test_rr_contention();
    test_fixed_priority();
    test_back_to_back();
    test_reset_req();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
